// File: rtl/rgen_pkg.sv
// ============================================================================
// Module : rgen_pkg
// Brief  : Shared types for the register-generator local bus controller.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rgen_pkg;

    // Bit 0 is forwarded upstream as pslverr.
    typedef enum logic [1:0] {
        OKAY         = 2'b00,
        SLAVE_ERROR  = 2'b01,
        DECODE_ERROR = 2'b11
    } rgen_status_e;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        ACCESS   = 2'b01,
        RESPONSE = 2'b10
    } rgen_bus_state_e;

endpackage

`default_nettype wire

// File: rtl/rgen_address_decoder.sv
// ============================================================================
// Module : rgen_address_decoder
// Brief  : Word-aligned address match against the register map; the
//          lowest-index match wins.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rgen_address_decoder #(
    parameter int DATA_WIDTH          = 32,
    parameter int LOCAL_ADDRESS_WIDTH = 16,
    parameter int REGISTERS           = 4,
    parameter logic [REGISTERS*LOCAL_ADDRESS_WIDTH-1:0] REGISTER_ADDRESSES =
        {16'h000C, 16'h0008, 16'h0004, 16'h0000}
) (
    input  logic [LOCAL_ADDRESS_WIDTH-1:0] i_address,
    output logic [REGISTERS-1:0]           o_select,
    output logic                           o_hit
);

    localparam int c_addr_lsb  = $clog2(DATA_WIDTH / 8);
    localparam int c_word_bits = LOCAL_ADDRESS_WIDTH - c_addr_lsb;

    logic [REGISTERS-1:0] w_match;

    for (genvar i = 0; i < REGISTERS; i++) begin : g_match
        assign w_match[i] = (i_address[LOCAL_ADDRESS_WIDTH-1:c_addr_lsb] ==
            REGISTER_ADDRESSES[i*LOCAL_ADDRESS_WIDTH + c_addr_lsb +: c_word_bits]);
    end

    // Isolate the lowest set bit to get lowest-index priority.
    assign o_select = w_match & (~w_match + REGISTERS'(1));
    assign o_hit    = |w_match;

    if (c_addr_lsb > 0) begin : g_low_bits
        logic w_unused_low;
        assign w_unused_low = ^i_address[c_addr_lsb-1:0];
    end

endmodule

`default_nettype wire

// File: rtl/rgen_local_bus_controller.sv
// ============================================================================
// Module : rgen_local_bus_controller
// Brief  : Sequences one register access per local-bus command and returns a
//          one-cycle response. Optional access timeout: RGEN_BUS_TIMEOUT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rgen_local_bus_controller
    import rgen_pkg::*;
#(
    parameter int DATA_WIDTH          = 32,
    parameter int LOCAL_ADDRESS_WIDTH = 16,
    parameter int REGISTERS           = 4,
    parameter logic [REGISTERS*LOCAL_ADDRESS_WIDTH-1:0] REGISTER_ADDRESSES =
        {16'h000C, 16'h0008, 16'h0004, 16'h0000},
    parameter int TIMEOUT_CYCLES      = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_command_valid,
    input  logic                            i_write,
    input  logic                            i_read,
    input  logic [LOCAL_ADDRESS_WIDTH-1:0]  i_address,
    input  logic [DATA_WIDTH-1:0]           i_write_data,
    input  logic [DATA_WIDTH-1:0]           i_write_mask,
    output logic                            o_response_ready,
    output logic [DATA_WIDTH-1:0]           o_read_data,
    output logic [1:0]                      o_status,
    output logic [REGISTERS-1:0]            o_register_select,
    output logic                            o_register_write,
    output logic [DATA_WIDTH-1:0]           o_register_write_data,
    output logic [DATA_WIDTH-1:0]           o_register_write_mask,
    input  logic [REGISTERS-1:0]            i_register_ready,
    input  logic [REGISTERS*DATA_WIDTH-1:0] i_register_read_data,
    input  logic [REGISTERS-1:0]            i_register_error
);

    if (REGISTERS < 1 || (DATA_WIDTH % 8) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("rgen_local_bus_controller: illegal parameter set");
    end

    rgen_bus_state_e        r_state, w_next_state;
    logic                   r_write, w_next_write;
    logic [DATA_WIDTH-1:0]  r_write_data, w_next_write_data;
    logic [DATA_WIDTH-1:0]  r_write_mask, w_next_write_mask;
    logic [REGISTERS-1:0]   r_select, w_next_select;
    logic                   r_response_ready, w_next_response_ready;
    logic [DATA_WIDTH-1:0]  r_read_data, w_next_read_data;
    rgen_status_e           r_status, w_next_status;

    logic [REGISTERS-1:0]   w_dec_select;
    logic                   w_dec_hit;
    logic                   w_cmd_write;
    logic                   w_sel_ready;
    logic                   w_sel_error;
    logic [DATA_WIDTH-1:0]  w_sel_read_data;
    logic                   w_timeout_expired;

    rgen_address_decoder #(
        .DATA_WIDTH         (DATA_WIDTH),
        .LOCAL_ADDRESS_WIDTH(LOCAL_ADDRESS_WIDTH),
        .REGISTERS          (REGISTERS),
        .REGISTER_ADDRESSES (REGISTER_ADDRESSES)
    ) u_decoder (
        .i_address(i_address),
        .o_select (w_dec_select),
        .o_hit    (w_dec_hit)
    );

    // Neither or both strobes set resolves to a read, which has no side effects.
    assign w_cmd_write = i_write & ~i_read;
    assign w_sel_ready = |(i_register_ready & r_select);
    assign w_sel_error = |(i_register_error & r_select);

`ifdef RGEN_BUS_TIMEOUT_EN
    localparam int c_timeout_width = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_timeout_width-1:0] r_timeout_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timeout_count <= '0;
        end else if (r_state != ACCESS) begin
            r_timeout_count <= '0;
        end else begin
            r_timeout_count <= r_timeout_count + c_timeout_width'(1);
        end
    end

    assign w_timeout_expired = (r_state == ACCESS) &&
                               (r_timeout_count == c_timeout_width'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout_expired = 1'b0;
`endif

    always_comb begin
        w_next_state          = r_state;
        w_next_write          = r_write;
        w_next_write_data     = r_write_data;
        w_next_write_mask     = r_write_mask;
        w_next_select         = r_select;
        w_next_response_ready = 1'b0;
        w_next_read_data      = r_read_data;
        w_next_status         = r_status;

        w_sel_read_data = '0;
        for (int i = 0; i < REGISTERS; i++) begin
            if (r_select[i]) begin
                w_sel_read_data = w_sel_read_data | i_register_read_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        case (r_state)
            IDLE: begin
                if (i_command_valid) begin
                    w_next_write      = w_cmd_write;
                    w_next_write_data = i_write_data;
                    w_next_write_mask = i_write_mask;
                    if (w_dec_hit) begin
                        w_next_select = w_dec_select;
                        w_next_state  = ACCESS;
                    end else begin
                        w_next_status         = DECODE_ERROR;
                        w_next_read_data      = '0;
                        w_next_response_ready = 1'b1;
                        w_next_state          = RESPONSE;
                    end
                end
            end
            ACCESS: begin
                if (w_sel_ready) begin
                    w_next_status         = w_sel_error ? SLAVE_ERROR : OKAY;
                    w_next_read_data      = r_write ? '0 : w_sel_read_data;
                    w_next_select         = '0;
                    w_next_response_ready = 1'b1;
                    w_next_state          = RESPONSE;
                end else if (w_timeout_expired) begin
                    w_next_status         = SLAVE_ERROR;
                    w_next_read_data      = '0;
                    w_next_select         = '0;
                    w_next_response_ready = 1'b1;
                    w_next_state          = RESPONSE;
                end
            end
            RESPONSE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_select = '0;
                w_next_state  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= IDLE;
            r_write          <= 1'b0;
            r_write_data     <= '0;
            r_write_mask     <= '0;
            r_select         <= '0;
            r_response_ready <= 1'b0;
            r_read_data      <= '0;
            r_status         <= OKAY;
        end else begin
            r_state          <= w_next_state;
            r_write          <= w_next_write;
            r_write_data     <= w_next_write_data;
            r_write_mask     <= w_next_write_mask;
            r_select         <= w_next_select;
            r_response_ready <= w_next_response_ready;
            r_read_data      <= w_next_read_data;
            r_status         <= w_next_status;
        end
    end

    assign o_response_ready      = r_response_ready;
    assign o_read_data           = r_read_data;
    assign o_status              = r_status;
    assign o_register_select     = r_select;
    assign o_register_write      = r_write;
    assign o_register_write_data = r_write_data;
    assign o_register_write_mask = r_write_mask;

endmodule

`default_nettype wire

// File: tb/tb_rgen_local_bus_controller.sv
// ============================================================================
// Module : tb_rgen_local_bus_controller
// Brief  : Self-checking bench for rgen_local_bus_controller.
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rgen_local_bus_controller;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int NR = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           i_command_valid, i_write, i_read;
    logic [AW-1:0]  i_address;
    logic [DW-1:0]  i_write_data, i_write_mask;
    logic           o_response_ready;
    logic [DW-1:0]  o_read_data;
    logic [1:0]     o_status;
    logic [NR-1:0]  o_register_select;
    logic           o_register_write;
    logic [DW-1:0]  o_register_write_data, o_register_write_mask;
    logic [NR-1:0]  i_register_ready, i_register_error;
    logic [NR*DW-1:0] i_register_read_data;

    always #5 clk = ~clk;

    rgen_local_bus_controller dut (
        .clk                  (clk),
        .rst                  (rst),
        .i_command_valid      (i_command_valid),
        .i_write              (i_write),
        .i_read               (i_read),
        .i_address            (i_address),
        .i_write_data         (i_write_data),
        .i_write_mask         (i_write_mask),
        .o_response_ready     (o_response_ready),
        .o_read_data          (o_read_data),
        .o_status             (o_status),
        .o_register_select    (o_register_select),
        .o_register_write     (o_register_write),
        .o_register_write_data(o_register_write_data),
        .o_register_write_mask(o_register_write_mask),
        .i_register_ready     (i_register_ready),
        .i_register_read_data (i_register_read_data),
        .i_register_error     (i_register_error)
    );

    typedef struct {
        logic          wr;
        logic          rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] wmask;
        logic [NR-1:0] sel;        // register expected to be selected, 0 = miss
        int            wait_n;     // wait cycles before the selected register is ready
        logic          err;
        logic [DW-1:0] reg_data;
        int            exp_lat;
        logic [1:0]    exp_status;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic [DW-1:0] rdata;
        logic [1:0]    status;
        int            lat;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[10];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Unselected registers are held ready and erroring with junk data; the DUT must ignore them.
    task automatic set_slaves(input logic [NR-1:0] sel, input logic ready_on, input logic err,
                              input logic [DW-1:0] data);
        i_register_ready = ~sel | (ready_on ? sel : '0);
        i_register_error = ~sel | (err ? sel : '0);
        for (int i = 0; i < NR; i++) begin
            i_register_read_data[i*DW +: DW] = sel[i] ? data : (32'hBAD0_0000 | DW'(i));
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int   cyc;
        int   acc;
        bit   done;
        exp_t e;
        i_command_valid = 1'b1;
        i_write         = v.wr;
        i_read          = v.rd;
        i_address       = v.addr;
        i_write_data    = v.wdata;
        i_write_mask    = v.wmask;
        set_slaves(v.sel, 1'b0, v.err, v.reg_data);
        sb_q.push_back('{rdata: v.exp_rdata, status: v.exp_status, lat: v.exp_lat});
        cyc  = 0;
        acc  = 0;
        done = 1'b0;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (o_register_select != '0) begin
                acc++;
                if (acc == 1) begin
                    check({tag, "_select"}, DW'(o_register_select), DW'(v.sel));
                    check({tag, "_write"}, DW'(o_register_write), DW'(v.wr & ~v.rd));
                    check({tag, "_wmask"}, o_register_write_mask, v.wmask);
                end
                check({tag, "_wdata"}, o_register_write_data, v.wdata);
                // Command inputs changing mid-access must not disturb the latched command.
                i_address    = v.addr ^ 16'h0FF4;
                i_write_data = ~v.wdata;
                i_write_mask = ~v.wmask;
                i_write      = ~v.wr;
            end
            if (o_response_ready) begin
                done            = 1'b1;
                i_command_valid = 1'b0;
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL %s_unexpected_response: got response, expected none queued", tag);
                end else begin
                    e = sb_q.pop_front();
                    check({tag, "_latency"}, DW'(cyc), DW'(e.lat));
                    check({tag, "_rdata"}, o_read_data, e.rdata);
                    check({tag, "_status"}, DW'(o_status), DW'(e.status));
                end
            end
            set_slaves(v.sel, (o_register_select != '0) && (acc == v.wait_n + 1), v.err, v.reg_data);
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got no response in 60 cycles, expected one", tag);
        end
        check({tag, "_select_cycles"}, DW'(acc), DW'((v.sel != '0) ? v.wait_n + 1 : 0));
        @(negedge clk);
        check({tag, "_resp_one_cycle"}, DW'(o_response_ready), 32'd0);
        check({tag, "_rdata_hold"}, o_read_data, v.exp_rdata);
        check({tag, "_status_hold"}, DW'(o_status), DW'(v.exp_status));
    endtask

    initial begin
        int  resp_cyc;
        bit  resp_seen;
        logic [DW-1:0] resp_rdata;
        logic [1:0]    resp_status;

        //           wr    rd    addr      wdata         wmask         sel    wait err  reg_data      lat st     exp_rdata
        vecs[0] = '{1'b1, 1'b0, 16'h0004, 32'hDEADBEEF, 32'h0000FFFF, 4'b0010, 0, 1'b0, 32'h11111111, 2, 2'b00, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 16'h0008, 32'h0,        32'h0,        4'b0100, 3, 1'b0, 32'h12345678, 5, 2'b00, 32'h12345678};
        vecs[2] = '{1'b0, 1'b1, 16'h0040, 32'h0,        32'h0,        4'b0000, 0, 1'b0, 32'h0,        1, 2'b11, 32'h0};
        vecs[3] = '{1'b0, 1'b1, 16'h000C, 32'h0,        32'h0,        4'b1000, 0, 1'b1, 32'hCAFEF00D, 2, 2'b01, 32'hCAFEF00D};
        vecs[4] = '{1'b1, 1'b0, 16'h0000, 32'h87654321, 32'hFF00FF00, 4'b0001, 1, 1'b0, 32'h22222222, 3, 2'b00, 32'h0};
        vecs[5] = '{1'b0, 1'b0, 16'h0007, 32'h0,        32'h0,        4'b0010, 2, 1'b0, 32'hA5A55A5A, 4, 2'b00, 32'hA5A55A5A};
        vecs[6] = '{1'b0, 1'b1, 16'h000E, 32'h0,        32'h0,        4'b1000, 0, 1'b0, 32'h0F0F0F0F, 2, 2'b00, 32'h0F0F0F0F};
        vecs[7] = '{1'b0, 1'b1, 16'h1004, 32'h0,        32'h0,        4'b0000, 0, 1'b0, 32'h0,        1, 2'b11, 32'h0};
        vecs[8] = '{1'b1, 1'b0, 16'h0008, 32'h13572468, 32'hFFFFFFFF, 4'b0100, 0, 1'b1, 32'h33333333, 2, 2'b01, 32'h0};
        vecs[9] = '{1'b1, 1'b0, 16'hFFFC, 32'h0,        32'h0,        4'b0000, 0, 1'b0, 32'h0,        1, 2'b11, 32'h0};

        rst = 1'b1;
        i_command_valid = 1'b0;
        i_write = 1'b0;
        i_read = 1'b0;
        i_address = '0;
        i_write_data = '0;
        i_write_mask = '0;
        set_slaves('0, 1'b0, 1'b0, '0);
        repeat (3) @(negedge clk);
        check("reset_response_ready", DW'(o_response_ready), 32'd0);
        check("reset_read_data", o_read_data, 32'd0);
        check("reset_status", DW'(o_status), 32'd0);
        check("reset_select", DW'(o_register_select), 32'd0);
        check("reset_write", DW'(o_register_write), 32'd0);
        check("reset_wdata", o_register_write_data, 32'd0);
        check("reset_wmask", o_register_write_mask, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Asynchronous reset in the middle of an access.
        i_command_valid = 1'b1;
        i_write = 1'b0;
        i_read = 1'b1;
        i_address = 16'h0008;
        set_slaves(4'b0100, 1'b0, 1'b0, 32'h55555555);
        @(negedge clk);
        check("rst_mid_select_before", DW'(o_register_select), 32'h4);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_select_after", DW'(o_register_select), 32'd0);
        check("rst_mid_response_ready", DW'(o_response_ready), 32'd0);
        check("rst_mid_read_data", o_read_data, 32'd0);
        i_command_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_vec(vecs[1], "after_rst");

        check("scoreboard_empty", DW'(sb_q.size()), 32'd0);

        // Selected register never becomes ready.
        i_command_valid = 1'b1;
        i_write = 1'b0;
        i_read = 1'b1;
        i_address = 16'h0000;
        set_slaves(4'b0001, 1'b0, 1'b0, 32'h77777777);
        resp_seen = 1'b0;
        resp_cyc = 0;
        resp_rdata = '0;
        resp_status = '0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (o_response_ready && !resp_seen) begin
                resp_seen = 1'b1;
                resp_cyc = c;
                resp_rdata = o_read_data;
                resp_status = o_status;
                i_command_valid = 1'b0;
            end
        end
`ifdef RGEN_BUS_TIMEOUT_EN
        check("timeout_seen", DW'(resp_seen), 32'd1);
        check("timeout_latency", DW'(resp_cyc), 32'd17);
        check("timeout_status", DW'(resp_status), 32'd1);
        check("timeout_rdata", resp_rdata, 32'd0);
`else
        check("no_timeout_response", DW'(resp_seen), 32'd0);
        check("no_timeout_select_held", DW'(o_register_select), 32'h1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
